// File: rtl/fifo_xfer_arb.sv
// fifo_xfer_arb
// Moves words from two first-word-fall-through source FIFOs into one sink
// FIFO. Sources are granted in bursts of up to BURST_LEN words. When both
// sources have data, the source that was not served last wins. The
// data/strobe path is combinational: a transfer pops the source and writes
// the sink in the same cycle.
//
// Optional feature: define XFER_STATS_EN to build the per-source transfer
// counters o_cnt0/o_cnt1, which wrap modulo 2^CNT_W. Without the macro they
// are tied to zero.
//
// Ports:
//   clk_30M   in   single clock, rising edge
//   nReset    in   synchronous active-low reset
//   i_en      in   arbitration enable
//   i_clr     in   synchronous soft clear, active-high, same effect as reset
//   i_rempty  in   [1:0] source empty flags, bit n = source n
//   i_rdata0  in   [DSIZE-1:0] head word of source 0
//   i_rdata1  in   [DSIZE-1:0] head word of source 1
//   o_rd      out  [1:0] pop strobes, bit n to source n
//   i_wfull   in   sink full flag
//   o_wr      out  sink write strobe
//   o_wdata   out  [DSIZE-1:0] sink write data
//   o_busy    out  high while serving a burst
//   o_grant   out  source currently (SERVE) or last (IDLE) served
//   o_cnt0    out  [CNT_W-1:0] words moved from source 0
//   o_cnt1    out  [CNT_W-1:0] words moved from source 1
module fifo_xfer_arb #(
    parameter int DSIZE     = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk_30M,
    input  logic             nReset,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [1:0]       i_rempty,
    input  logic [DSIZE-1:0] i_rdata0,
    input  logic [DSIZE-1:0] i_rdata1,
    output logic [1:0]       o_rd,
    input  logic             i_wfull,
    output logic             o_wr,
    output logic [DSIZE-1:0] o_wdata,
    output logic             o_busy,
    output logic             o_grant,
    output logic [CNT_W-1:0] o_cnt0,
    output logic [CNT_W-1:0] o_cnt1
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam logic [7:0] BCNT_LAST = 8'(BURST_LEN - 1);

    state_t     state;
    logic       sel;
    logic       last;
    logic [7:0] bcnt;

    logic       rst_now;
    logic       sel_empty;
    logic       serving;
    logic       xfer;
    logic       pick;

    // Clear and reset are equivalent and also suppress every output in the
    // cycle they are asserted, so a burst aborts without a stray strobe.
    assign rst_now   = !nReset || i_clr;
    assign sel_empty = sel ? i_rempty[1] : i_rempty[0];
    assign serving   = !rst_now && (state == SERVE);
    assign xfer      = serving && i_en && !sel_empty && !i_wfull;

    // Round-robin choice: a lone non-empty source wins outright, otherwise
    // the source not served last.
    always_comb begin
        pick = 1'b0;
        if (!i_rempty[0] && !i_rempty[1])
            pick = ~last;
        else if (i_rempty[0])
            pick = 1'b1;
        else
            pick = 1'b0;
    end

    always_ff @(posedge clk_30M) begin
        if (rst_now) begin
            state <= IDLE;
            bcnt  <= '0;
            last  <= 1'b1;
            sel   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (i_en && (i_rempty != 2'b11)) begin
                        sel   <= pick;
                        bcnt  <= '0;
                        state <= SERVE;
                    end
                end
                SERVE: begin
                    if (!i_en || sel_empty) begin
                        last  <= sel;
                        state <= IDLE;
                    end else if (!i_wfull) begin
                        if (bcnt == BCNT_LAST) begin
                            last  <= sel;
                            state <= IDLE;
                        end else begin
                            bcnt <= bcnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_rd    = xfer ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign o_wr    = xfer;
    assign o_wdata = serving ? (sel ? i_rdata1 : i_rdata0) : '0;
    assign o_busy  = serving;
    assign o_grant = rst_now ? 1'b1 : ((state == SERVE) ? sel : last);

`ifdef XFER_STATS_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    always_ff @(posedge clk_30M) begin
        if (rst_now) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (xfer) begin
            if (sel)
                cnt1 <= cnt1 + 1'b1;
            else
                cnt0 <= cnt0 + 1'b1;
        end
    end

    assign o_cnt0 = cnt0;
    assign o_cnt1 = cnt1;
`else
    assign o_cnt0 = '0;
    assign o_cnt1 = '0;
`endif

endmodule

// File: tb/tb_fifo_xfer_arb.sv
// Directed testbench for fifo_xfer_arb (BURST_LEN=4, CNT_W=4). Source
// FIFOs are modelled by queues; outputs are sampled at the falling edge and
// pops are applied just after the rising edge.
module tb_fifo_xfer_arb;

    logic       clk_30M = 1'b0;
    logic       nReset;
    logic       i_en;
    logic       i_clr;
    logic [1:0] i_rempty;
    logic [7:0] i_rdata0;
    logic [7:0] i_rdata1;
    logic [1:0] o_rd;
    logic       i_wfull;
    logic       o_wr;
    logic [7:0] o_wdata;
    logic       o_busy;
    logic       o_grant;
    logic [3:0] o_cnt0;
    logic [3:0] o_cnt1;

    int nchecks = 0;
    int nerrors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] sink[$];
    logic       sink_g[$];

    logic [1:0] s_rd;
    logic       s_wr;
    logic [7:0] s_wdata;
    logic       s_busy;
    logic       s_grant;

    fifo_xfer_arb #(
        .DSIZE    (8),
        .BURST_LEN(4),
        .CNT_W    (4)
    ) dut (
        .clk_30M (clk_30M),
        .nReset  (nReset),
        .i_en    (i_en),
        .i_clr   (i_clr),
        .i_rempty(i_rempty),
        .i_rdata0(i_rdata0),
        .i_rdata1(i_rdata1),
        .o_rd    (o_rd),
        .i_wfull (i_wfull),
        .o_wr    (o_wr),
        .o_wdata (o_wdata),
        .o_busy  (o_busy),
        .o_grant (o_grant),
        .o_cnt0  (o_cnt0),
        .o_cnt1  (o_cnt1)
    );

    always #5 clk_30M = ~clk_30M;

    function automatic void drive();
        i_rempty = {q1.size() == 0, q0.size() == 0};
        i_rdata0 = (q0.size() > 0) ? q0[0] : 8'h00;
        i_rdata1 = (q1.size() > 0) ? q1[0] : 8'h00;
    endfunction

    // One clock: sample outputs mid-cycle, then pop sources after the edge.
    task automatic step();
        @(negedge clk_30M);
        s_rd    = o_rd;
        s_wr    = o_wr;
        s_wdata = o_wdata;
        s_busy  = o_busy;
        s_grant = o_grant;
        if (s_wr) begin
            sink.push_back(s_wdata);
            sink_g.push_back(s_grant);
        end
        @(posedge clk_30M);
        #1;
        if (s_rd[0] && q0.size() > 0) void'(q0.pop_front());
        if (s_rd[1] && q1.size() > 0) void'(q1.pop_front());
        drive();
    endtask

    task automatic do_reset();
        q0.delete();
        q1.delete();
        drive();
        i_en    = 1'b1;
        i_clr   = 1'b0;
        i_wfull = 1'b0;
        nReset  = 1'b0;
        @(posedge clk_30M);
        @(posedge clk_30M);
        #1;
        nReset = 1'b1;
        sink.delete();
        sink_g.delete();
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        i_en   = 1'b1;
        q0.delete();
        q1.delete();
        for (int k = 0; k < 3; k++) q0.push_back(8'(k + 1));
        drive();
        for (int c = 0; c < 3; c++) begin
            step();
            nchecks++;
            if ({s_rd, s_wr, s_wdata, s_busy, s_grant} !== {2'b00, 1'b0, 8'h00, 1'b0, 1'b1}) begin
                nerrors++;
                $display("FAIL reset_outputs cyc=%0d: rd=%b wr=%b wdata=%h busy=%b grant=%b, expected rd=00 wr=0 wdata=00 busy=0 grant=1",
                         c, s_rd, s_wr, s_wdata, s_busy, s_grant);
            end
            nchecks++;
            if ({o_cnt0, o_cnt1} !== 8'h00) begin
                nerrors++;
                $display("FAIL reset_counters: cnt0=%0d cnt1=%0d, expected 0 0", o_cnt0, o_cnt1);
            end
        end
        nchecks++;
        if (q0.size() != 3) begin
            nerrors++;
            $display("FAIL reset_no_pop: q0 size=%0d, expected 3", q0.size());
        end
    endtask

    task automatic test_single_source();
        logic exp_wr[15]   = '{0,1,1,1,1,0,1,1,1,1,0,1,1,0,0};
        logic exp_busy[15] = '{0,1,1,1,1,0,1,1,1,1,0,1,1,1,0};
        do_reset();
        for (int k = 1; k <= 10; k++) q0.push_back(8'(k));
        drive();
        for (int c = 0; c < 15; c++) begin
            step();
            nchecks++;
            if ({s_wr, s_rd, s_busy} !== {exp_wr[c], 1'b0, exp_wr[c], exp_busy[c]}) begin
                nerrors++;
                $display("FAIL single_strobes cyc=%0d: wr=%b rd=%b busy=%b, expected wr=%b rd=0%b busy=%b",
                         c, s_wr, s_rd, s_busy, exp_wr[c], exp_wr[c], exp_busy[c]);
            end
            nchecks++;
            if (s_grant !== (c == 0)) begin
                nerrors++;
                $display("FAIL single_grant cyc=%0d: grant=%b, expected %b", c, s_grant, c == 0);
            end
        end
        nchecks++;
        if (sink.size() != 10) begin
            nerrors++;
            $display("FAIL single_count: got %0d words, expected 10", sink.size());
        end
        for (int i = 0; i < sink.size() && i < 10; i++) begin
            nchecks++;
            if (sink[i] !== 8'(i + 1)) begin
                nerrors++;
                $display("FAIL single_data[%0d]: got %h, expected %h", i, sink[i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_alternate();
        logic [7:0] exp_w;
        logic       exp_g;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            q0.push_back(8'(8'hA0 + k));
            q1.push_back(8'(8'hB0 + k));
        end
        drive();
        for (int c = 0; c < 22; c++) step();
        nchecks++;
        if (sink.size() != 16) begin
            nerrors++;
            $display("FAIL alt_count: got %0d words, expected 16", sink.size());
        end
        for (int i = 0; i < sink.size() && i < 16; i++) begin
            exp_g = ((i / 4) % 2) == 1;
            exp_w = 8'((exp_g ? 8'hB0 : 8'hA0) + (i / 8) * 4 + (i % 4));
            nchecks++;
            if (sink[i] !== exp_w || sink_g[i] !== exp_g) begin
                nerrors++;
                $display("FAIL alt_order[%0d]: got %h grant=%b, expected %h grant=%b",
                         i, sink[i], sink_g[i], exp_w, exp_g);
            end
        end
    endtask

    task automatic test_stall();
        logic exp_wr[9]   = '{0,1,1,0,0,0,1,1,0};
        logic exp_busy[9] = '{0,1,1,1,1,1,1,1,0};
        do_reset();
        for (int k = 0; k < 8; k++) q0.push_back(8'(8'h10 + k));
        drive();
        for (int c = 0; c < 9; c++) begin
            i_wfull = (c >= 3 && c <= 5);
            step();
            nchecks++;
            if ({s_wr, s_rd, s_busy} !== {exp_wr[c], 1'b0, exp_wr[c], exp_busy[c]}) begin
                nerrors++;
                $display("FAIL stall_strobes cyc=%0d: wr=%b rd=%b busy=%b, expected wr=%b rd=0%b busy=%b",
                         c, s_wr, s_rd, s_busy, exp_wr[c], exp_wr[c], exp_busy[c]);
            end
        end
        i_wfull = 1'b0;
        nchecks++;
        if (sink.size() != 4) begin
            nerrors++;
            $display("FAIL stall_count: got %0d words, expected 4", sink.size());
        end
        for (int i = 0; i < sink.size() && i < 4; i++) begin
            nchecks++;
            if (sink[i] !== 8'(8'h10 + i)) begin
                nerrors++;
                $display("FAIL stall_data[%0d]: got %h, expected %h", i, sink[i], 8'(8'h10 + i));
            end
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            q0.push_back(8'(8'hA0 + k));
            q1.push_back(8'(8'hB0 + k));
        end
        drive();
        for (int c = 0; c < 3; c++) step();
        nReset = 1'b0;
        step();
        nchecks++;
        if ({s_rd, s_wr, s_wdata, s_busy, s_grant} !== {2'b00, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            nerrors++;
            $display("FAIL midrst_cycle: rd=%b wr=%b wdata=%h busy=%b grant=%b, expected 00 0 00 0 1",
                     s_rd, s_wr, s_wdata, s_busy, s_grant);
        end
        nReset = 1'b1;
        step();
        nchecks++;
        if ({s_wr, s_busy, s_grant} !== 3'b001) begin
            nerrors++;
            $display("FAIL midrst_after: wr=%b busy=%b grant=%b, expected wr=0 busy=0 grant=1",
                     s_wr, s_busy, s_grant);
        end
        step();
        nchecks++;
        if ({s_wr, s_grant, s_wdata} !== {1'b1, 1'b0, 8'hA2}) begin
            nerrors++;
            $display("FAIL midrst_restart: wr=%b grant=%b wdata=%h, expected wr=1 grant=0 wdata=a2",
                     s_wr, s_grant, s_wdata);
        end
    endtask

    task automatic test_clear();
        do_reset();
        for (int k = 0; k < 4; k++) q0.push_back(8'(8'h30 + k));
        drive();
        for (int c = 0; c < 2; c++) step();
        i_clr = 1'b1;
        step();
        nchecks++;
        if ({s_rd, s_wr, s_busy, s_grant} !== {2'b00, 1'b0, 1'b0, 1'b1}) begin
            nerrors++;
            $display("FAIL clr_cycle: rd=%b wr=%b busy=%b grant=%b, expected 00 0 0 1",
                     s_rd, s_wr, s_busy, s_grant);
        end
        i_clr = 1'b0;
        step();
        nchecks++;
        if ({s_wr, s_busy, s_grant, o_cnt0} !== {1'b0, 1'b0, 1'b1, 4'd0}) begin
            nerrors++;
            $display("FAIL clr_after: wr=%b busy=%b grant=%b cnt0=%0d, expected 0 0 1 0",
                     s_wr, s_busy, s_grant, o_cnt0);
        end
        step();
        nchecks++;
        if ({s_wr, s_grant, s_wdata} !== {1'b1, 1'b0, 8'h31}) begin
            nerrors++;
            $display("FAIL clr_restart: wr=%b grant=%b wdata=%h, expected wr=1 grant=0 wdata=31",
                     s_wr, s_grant, s_wdata);
        end
    endtask

    task automatic test_en_drop();
        do_reset();
        for (int k = 0; k < 8; k++) q0.push_back(8'(8'h50 + k));
        drive();
        for (int c = 0; c < 3; c++) step();
        i_en = 1'b0;
        step();
        nchecks++;
        if ({s_wr, s_rd, s_busy} !== {1'b0, 2'b00, 1'b1}) begin
            nerrors++;
            $display("FAIL endrop_cycle: wr=%b rd=%b busy=%b, expected wr=0 rd=00 busy=1", s_wr, s_rd, s_busy);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            nchecks++;
            if ({s_wr, s_busy, s_grant} !== 3'b000) begin
                nerrors++;
                $display("FAIL endrop_idle cyc=%0d: wr=%b busy=%b grant=%b, expected 0 0 0",
                         c, s_wr, s_busy, s_grant);
            end
        end
        i_en = 1'b1;
        step();
        nchecks++;
        if ({s_wr, s_busy} !== 2'b00) begin
            nerrors++;
            $display("FAIL endrop_rearm: wr=%b busy=%b, expected 0 0", s_wr, s_busy);
        end
        step();
        nchecks++;
        if ({s_wr, s_busy, s_wdata} !== {1'b1, 1'b1, 8'h52}) begin
            nerrors++;
            $display("FAIL endrop_resume: wr=%b busy=%b wdata=%h, expected 1 1 52", s_wr, s_busy, s_wdata);
        end
    endtask

    task automatic test_counters();
        logic [3:0] exp0;
`ifdef XFER_STATS_EN
        exp0 = 4'd1;
`else
        exp0 = 4'd0;
`endif
        do_reset();
        for (int k = 0; k < 17; k++) q0.push_back(8'(k));
        drive();
        for (int c = 0; c < 40 && q0.size() > 0; c++) begin
            step();
`ifndef XFER_STATS_EN
            nchecks++;
            if ({o_cnt0, o_cnt1} !== 8'h00) begin
                nerrors++;
                $display("FAIL cnt_tied cyc=%0d: cnt0=%0d cnt1=%0d, expected 0 0", c, o_cnt0, o_cnt1);
            end
`endif
        end
        nchecks++;
        if (q0.size() != 0) begin
            nerrors++;
            $display("FAIL cnt_drain: %0d words left after cycle budget, expected 0", q0.size());
        end
        step();
        nchecks++;
        if (o_cnt0 !== exp0 || o_cnt1 !== 4'd0) begin
            nerrors++;
            $display("FAIL cnt_final: cnt0=%0d cnt1=%0d, expected %0d 0", o_cnt0, o_cnt1, exp0);
        end
    endtask

    initial begin
        nReset  = 1'b0;
        i_en    = 1'b0;
        i_clr   = 1'b0;
        i_wfull = 1'b0;
        drive();
        #1;
        test_reset();
        test_single_source();
        test_alternate();
        test_stall();
        test_reset_midburst();
        test_clear();
        test_en_drop();
        test_counters();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
